// File: rtl/freq_gate_ctrl_pkg.sv
// Shared types and default parameters for the frequency-gate controller.
package freq_gate_ctrl_pkg;

  localparam int unsigned CntWDefault     = 32;
  localparam int unsigned GateWDefault    = 32;
  localparam int unsigned SettleCycDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StLatch,
    StDone
  } state_e;

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control/result bundle between a host (master) and the gate controller (slave).
interface freq_gate_ctrl_if
  import freq_gate_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned GATE_W = GateWDefault
);

  logic              start;
  logic              cont;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic [CNT_W-1:0]  count_in;
  logic              cnt_clr_n;
  logic              gate_en;
  logic [CNT_W-1:0]  result;
  logic              result_ovf;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              cfg_err;

  modport master (
    output start, cont, abort, gate_len, count_in, result_ready,
    input  cnt_clr_n, gate_en, result, result_ovf, result_valid, busy, cfg_err
  );

  modport slave (
    input  start, cont, abort, gate_len, count_in, result_ready,
    output cnt_clr_n, gate_en, result, result_ovf, result_valid, busy, cfg_err
  );

endinterface

// File: rtl/gate_timer.sv
// Gate-window down-counter: loaded with the window length, expires on its last cycle.
module gate_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A remaining count of one marks the final enabled cycle of the window.
  assign expire_o = en_i && (cnt_q == Width'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency-measurement gate controller: clears an external edge counter, opens a
// gate window of programmable length, waits for the counter to settle, latches the
// count and presents it through a valid/ready handshake.
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned GATE_W     = GateWDefault,
  parameter int unsigned SETTLE_CYC = SettleCycDefault
) (
  input logic                   clk_i,
  input logic                   rst_i,
  freq_gate_ctrl_if.slave       ctrl_io
);

  localparam int unsigned SettleW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   gate_len_q, gate_len_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                cfg_err_q, cfg_err_d;
  logic                cnt_clr_n_q;
  logic                tmr_load, tmr_en, tmr_expire;

  gate_timer #(
    .Width (GATE_W)
  ) u_gate_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (gate_len_q),
    .expire_o   (tmr_expire)
  );

  // Next-state and datapath update; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    gate_len_d = gate_len_q;
    settle_d   = settle_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    cfg_err_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    if (ctrl_io.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_io.start) begin
            if (ctrl_io.gate_len == '0) begin
              cfg_err_d = 1'b1;
            end else begin
              gate_len_d = ctrl_io.gate_len;
              state_d    = StClear;
            end
          end
        end
        StClear: begin
          tmr_load = 1'b1;
          state_d  = StGate;
        end
        StGate: begin
          tmr_en = 1'b1;
          if (tmr_expire) begin
            if (SETTLE_CYC == 0) begin
              state_d = StLatch;
            end else begin
              settle_d = SettleW'(SETTLE_CYC);
              state_d  = StSettle;
            end
          end
        end
        StSettle: begin
          if (settle_q <= SettleW'(1)) begin
            state_d = StLatch;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        StLatch: begin
          result_d = ctrl_io.count_in;
          ovf_d    = &ctrl_io.count_in;
          state_d  = StDone;
        end
        StDone: begin
          if (ctrl_io.result_ready) begin
            state_d = ctrl_io.cont ? StClear : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers; the counter clear is registered so it is low
  // during reset and rises on the first edge after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      gate_len_q  <= '0;
      settle_q    <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_clr_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_len_q  <= gate_len_d;
      settle_q    <= settle_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      cfg_err_q   <= cfg_err_d;
      cnt_clr_n_q <= (state_d != StClear);
    end
  end

  assign ctrl_io.cnt_clr_n    = cnt_clr_n_q;
  assign ctrl_io.gate_en      = (state_q == StGate);
  assign ctrl_io.result       = result_q;
  assign ctrl_io.result_ovf   = ovf_q;
  assign ctrl_io.result_valid = (state_q == StDone);
  assign ctrl_io.busy         = (state_q != StIdle);
  assign ctrl_io.cfg_err      = cfg_err_q;

endmodule
